// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   DATA_W / HALF_W : operand width and the width of one pipeline stage's adder
//   OP_ADD / OP_SUB : encoding of the op_sub control bit
//   flags_t         : condition flags produced alongside an arithmetic result
package alu_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/bk_adder32.sv
// Combinational 32-bit Brent-Kung prefix adder.
//   a, b     : addends
//   cin      : carry into bit 0
//   s        : sum, modulo 2^32
//   c_msb_in : carry into bit 31 (used for signed overflow of the upper half)
//   cout     : carry out of bit 31
//
// Stage 0 holds bitwise generate/propagate. Stages 1..LG form the up-sweep
// (span doubles per stage). Stages LG+1..2*LG-1 form the down-sweep, which
// fills in the remaining prefixes. Each stage is its own signal, so no
// signal feeds back on itself. The carry-in is merged after the tree, which
// keeps every group propagate term in use.
module bk_adder32
  import alu_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] s,
  output logic              c_msb_in,
  output logic              cout
);

  localparam int LG  = $clog2(HALF_W);
  localparam int NST = 2 * LG;

  logic [HALF_W:0] c;

  genvar gk, gi;
  generate
    for (gk = 0; gk < NST; gk++) begin : st
      logic [HALF_W-1:0] g;
      logic [HALF_W-1:0] p;

      if (gk == 0) begin : g_leaf
        assign g = a & b;
        assign p = a ^ b;
      end else begin : g_tree
        // Distance to the partner node combined at this stage.
        localparam int D = (gk <= LG) ? (2 ** (gk - 1)) : (2 ** (2 * LG - 1 - gk));

        for (gi = 0; gi < HALF_W; gi++) begin : g_bit
          localparam bit HIT = (gk <= LG)
                               ? (((gi + 1) % (2 * D)) == 0)
                               : ((((gi + 1) % (2 * D)) == D) && ((gi + 1) > 2 * D));
          if (HIT) begin : g_node
            assign g[gi] = st[gk-1].g[gi] | (st[gk-1].p[gi] & st[gk-1].g[gi-D]);
            assign p[gi] = st[gk-1].p[gi] & st[gk-1].p[gi-D];
          end else begin : g_pass
            assign g[gi] = st[gk-1].g[gi];
            assign p[gi] = st[gk-1].p[gi];
          end
        end
      end
    end

    // After the final stage, (g, p)[i] cover bits i..0; fold in the carry-in.
    assign c[0] = cin;
    for (gi = 0; gi < HALF_W; gi++) begin : g_carry
      assign c[gi+1] = st[NST-1].g[gi] | (st[NST-1].p[gi] & cin);
    end
  endgenerate

  assign s        = st[0].p ^ c[HALF_W-1:0];
  assign c_msb_in = c[HALF_W-1];
  assign cout     = c[HALF_W];

endmodule

// File: rtl/bk_subtractor_pipe64.sv
// Two-stage pipelined 64-bit add/subtract unit with valid/ready handshake.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : input handshake; in_ready depends combinationally on out_ready
//   in_a, in_b          : operands
//   in_op_sub           : 1 = a - b, 0 = a + b
//   in_tag              : opaque tag returned with the result
//   out_valid/out_ready : output handshake
//   out_res             : result modulo 2^64
//   out_carry           : carry out of bit 63 (for subtract: 1 = no borrow)
//   out_zero, out_neg   : result is zero / result bit 63
//   out_ovf             : signed overflow
//   out_tag             : tag of the result
// Stage 1 adds the low halves; stage 2 adds the high halves with the
// registered carry out of bit 31.
module bk_subtractor_pipe64
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_op_sub,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf,
  output logic [TAG_W-1:0]  out_tag
);

  // Stage 1 registers
  logic              s1_valid_reg;
  logic [HALF_W-1:0] s1_lo_reg;
  logic              s1_c32_reg;
  logic [HALF_W-1:0] s1_a_hi_reg;
  logic [HALF_W-1:0] s1_bb_hi_reg;
  logic [TAG_W-1:0]  s1_tag_reg;

  // Stage 2 registers
  logic              s2_valid_reg;
  logic [HALF_W-1:0] s2_lo_reg;
  logic [HALF_W-1:0] s2_hi_reg;
  logic              s2_c63_reg;
  logic              s2_c64_reg;
  logic [TAG_W-1:0]  s2_tag_reg;

  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  logic [DATA_W-1:0] bb;
  logic [HALF_W-1:0] lo_sum;
  logic              lo_c32;
  logic              lo_c31_unused;  // carry into bit 31 of the low half has no consumer
  logic [HALF_W-1:0] hi_sum;
  logic              hi_c63;
  logic              hi_c64;

  flags_t flags;

  // Handshake: stage 2 can take new data when empty or being drained;
  // stage 1 can take new data when empty or moving into stage 2.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_adv;
  assign in_ready = !s1_valid_reg || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // Subtraction is a + ~b + 1; the +1 comes in as carry-in of the low half.
  assign bb = in_op_sub ? ~in_b : in_b;

  bk_adder32 u_add_lo (
    .a        (in_a[HALF_W-1:0]),
    .b        (bb[HALF_W-1:0]),
    .cin      (in_op_sub),
    .s        (lo_sum),
    .c_msb_in (lo_c31_unused),
    .cout     (lo_c32)
  );

  bk_adder32 u_add_hi (
    .a        (s1_a_hi_reg),
    .b        (s1_bb_hi_reg),
    .cin      (s1_c32_reg),
    .s        (hi_sum),
    .c_msb_in (hi_c63),
    .cout     (hi_c64)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_lo_reg    <= '0;
      s1_c32_reg   <= 1'b0;
      s1_a_hi_reg  <= '0;
      s1_bb_hi_reg <= '0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_lo_reg    <= '0;
      s2_hi_reg    <= '0;
      s2_c63_reg   <= 1'b0;
      s2_c64_reg   <= 1'b0;
      s2_tag_reg   <= '0;
    end else begin
      if (in_fire) begin
        s1_lo_reg    <= lo_sum;
        s1_c32_reg   <= lo_c32;
        s1_a_hi_reg  <= in_a[DATA_W-1:HALF_W];
        s1_bb_hi_reg <= bb[DATA_W-1:HALF_W];
        s1_tag_reg   <= in_tag;
      end
      s1_valid_reg <= in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_reg);

      if (s2_adv) begin
        // With s2 advancing, an empty s1 leaves s2 empty.
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_lo_reg  <= s1_lo_reg;
          s2_hi_reg  <= hi_sum;
          s2_c63_reg <= hi_c63;
          s2_c64_reg <= hi_c64;
          s2_tag_reg <= s1_tag_reg;
        end
      end
    end
  end

  // Flags come from stage-2 registers only, so they hold while stalled.
  always_comb begin
    flags       = '0;
    flags.carry = s2_c64_reg;
    flags.zero  = ~|{s2_hi_reg, s2_lo_reg};
    flags.neg   = s2_hi_reg[HALF_W-1];
    flags.ovf   = s2_c63_reg ^ s2_c64_reg;
  end

  assign out_valid = s2_valid_reg;
  assign out_res   = {s2_hi_reg, s2_lo_reg};
  assign out_carry = flags.carry;
  assign out_zero  = flags.zero;
  assign out_neg   = flags.neg;
  assign out_ovf   = flags.ovf;
  assign out_tag   = s2_tag_reg;

  // A stalled offer must stay offered with unchanged payload.
  property p_hold_stable;
    @(posedge clk) disable iff (rst)
      (in_valid && !in_ready) |=> (in_valid && $stable({in_a, in_b, in_op_sub, in_tag}));
  endproperty
  a_hold_stable: assert property (p_hold_stable);

endmodule
